// File: rtl/video_timing_gen.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : video_timing_gen
// Brief    : Parametrised raster timing with a coordinate request stage that
//            leads DE by LEAD cycles, so a pipelined source lines up with DE.
// Revision : 1.0 - initial release
// ============================================================================
module video_timing_gen #(
    parameter int H_ACTIVE   = 1280,
    parameter int H_FP       = 110,
    parameter int H_SYNC     = 40,
    parameter int H_BP       = 220,
    parameter int V_ACTIVE   = 720,
    parameter int V_FP       = 5,
    parameter int V_SYNC     = 5,
    parameter int V_BP       = 20,
    parameter int H_SYNC_POL = 1,
    parameter int V_SYNC_POL = 1,
    parameter int LEAD       = 2,
    parameter int CNT_W      = 12,
    parameter int DATA_W     = 24
) (
    input  logic              clk_pix,
    input  logic              rst,
    input  logic              en,
    output logic              req_valid,
    output logic [CNT_W-1:0]  req_x,
    output logic [CNT_W-1:0]  req_y,
    input  logic [DATA_W-1:0] pix_data_in,
    output logic              vid_de,
    output logic              vid_hsync,
    output logic              vid_vsync,
    output logic [DATA_W-1:0] vid_data,
    output logic              frame_start,
    output logic              line_start,
    output logic [15:0]       frame_cnt
);

    localparam int c_H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int c_V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // Inclusive bounds so a range ending exactly at TOTAL never truncates.
    localparam logic [CNT_W-1:0] c_H_LAST    = CNT_W'(c_H_TOTAL - 1);
    localparam logic [CNT_W-1:0] c_V_LAST    = CNT_W'(c_V_TOTAL - 1);
    localparam logic [CNT_W-1:0] c_H_ACT_LST = CNT_W'(H_ACTIVE - 1);
    localparam logic [CNT_W-1:0] c_V_ACT_LST = CNT_W'(V_ACTIVE - 1);
    localparam logic [CNT_W-1:0] c_HS_BEG    = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] c_HS_LST    = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [CNT_W-1:0] c_VS_BEG    = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] c_VS_LST    = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic             c_HS_ON     = (H_SYNC_POL != 0);
    localparam logic             c_VS_ON     = (V_SYNC_POL != 0);

    generate
        if (LEAD < 0 || LEAD > 15) begin : g_err_lead
            $error("video_timing_gen: LEAD must be within 0..15");
        end
        if ((((c_H_TOTAL - 1) >> CNT_W) != 0) || (((c_V_TOTAL - 1) >> CNT_W) != 0)) begin : g_err_cnt
            $error("video_timing_gen: H_TOTAL/V_TOTAL do not fit CNT_W");
        end
    endgenerate

    typedef struct packed {
        logic valid;
        logic raw_h;
        logic raw_v;
        logic sof;
        logic sol;
    } stage_t;

    logic [CNT_W-1:0] r_h_cnt;
    logic [CNT_W-1:0] r_v_cnt;

    always_ff @(posedge clk_pix) begin
        if (rst || !en) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (r_h_cnt == c_H_LAST) begin
            r_h_cnt <= '0;
            r_v_cnt <= (r_v_cnt == c_V_LAST) ? '0 : r_v_cnt + CNT_W'(1);
        end else begin
            r_h_cnt <= r_h_cnt + CNT_W'(1);
        end
    end

    // Stage 0: everything is forced inactive while held in reset or disabled.
    logic   w_run;
    logic   w_req_valid;
    stage_t w_stage0;
    stage_t w_tap;

    assign w_run       = !rst && en;
    assign w_req_valid = w_run && (r_h_cnt <= c_H_ACT_LST) && (r_v_cnt <= c_V_ACT_LST);

    assign w_stage0.valid = w_req_valid;
    assign w_stage0.raw_h = w_run && (r_h_cnt >= c_HS_BEG) && (r_h_cnt <= c_HS_LST);
    assign w_stage0.raw_v = w_run && (r_v_cnt >= c_VS_BEG) && (r_v_cnt <= c_VS_LST);
    assign w_stage0.sol   = w_req_valid && (r_h_cnt == '0);
    assign w_stage0.sof   = w_req_valid && (r_h_cnt == '0) && (r_v_cnt == '0);

    assign req_valid = w_req_valid;
    assign req_x     = w_req_valid ? r_h_cnt : '0;
    assign req_y     = w_req_valid ? r_v_cnt : '0;

    generate
        if (LEAD == 0) begin : g_no_lead
            assign w_tap = w_stage0;
        end else begin : g_lead
            stage_t r_pipe [LEAD];

            always_ff @(posedge clk_pix) begin
                if (rst) begin
                    for (int i = 0; i < LEAD; i++) begin
                        r_pipe[i] <= '0;
                    end
                end else begin
                    r_pipe[0] <= w_stage0;
                    for (int i = 1; i < LEAD; i++) begin
                        r_pipe[i] <= r_pipe[i-1];
                    end
                end
            end

            assign w_tap = r_pipe[LEAD-1];
        end
    endgenerate

    logic              r_vid_de;
    logic              r_vid_hsync;
    logic              r_vid_vsync;
    logic [DATA_W-1:0] r_vid_data;
    logic              r_frame_start;
    logic              r_line_start;
    logic [15:0]       r_frame_cnt;

    // Source data arrives on the cycle its request reaches the tap.
    always_ff @(posedge clk_pix) begin
        if (rst) begin
            r_vid_de      <= 1'b0;
            r_vid_hsync   <= !c_HS_ON;
            r_vid_vsync   <= !c_VS_ON;
            r_vid_data    <= '0;
            r_frame_start <= 1'b0;
            r_line_start  <= 1'b0;
            r_frame_cnt   <= '0;
        end else begin
            r_vid_de      <= w_tap.valid;
            r_vid_hsync   <= w_tap.raw_h ? c_HS_ON : !c_HS_ON;
            r_vid_vsync   <= w_tap.raw_v ? c_VS_ON : !c_VS_ON;
            r_vid_data    <= w_tap.valid ? pix_data_in : '0;
            r_frame_start <= w_tap.sof;
            r_line_start  <= w_tap.sol;
            if (w_tap.sof) begin
                r_frame_cnt <= r_frame_cnt + 16'd1;
            end
        end
    end

    assign vid_de      = r_vid_de;
    assign vid_hsync   = r_vid_hsync;
    assign vid_vsync   = r_vid_vsync;
    assign vid_data    = r_vid_data;
    assign frame_start = r_frame_start;
    assign line_start  = r_line_start;
    assign frame_cnt   = r_frame_cnt;

endmodule
`default_nettype wire

// File: doc/video_timing_gen.md
Name: video_timing_gen

Overview:
Parametrised video timing generator, the successor to the fixed 720p HDMI timing logic. It drives rgb2dvi-style sinks with per-axis porch/sync/active geometry, programmable sync polarity and a pixel-fetch lead. The lead lets a pipelined pixel source with LEAD-cycle latency return data exactly aligned with DE. It sits between the frame-buffer/pattern source and the TMDS encoder, in the pixel clock domain.

Parameters:
H_ACTIVE, 1280, active pixels per line
H_FP, 110, horizontal front porch (pixels)
H_SYNC, 40, hsync width (pixels)
H_BP, 220, horizontal back porch (pixels)
V_ACTIVE, 720, active lines per frame
V_FP, 5, vertical front porch (lines)
V_SYNC, 5, vsync width (lines)
V_BP, 20, vertical back porch (lines)
H_SYNC_POL, 1, hsync active level
V_SYNC_POL, 1, vsync active level
LEAD, 2, pixel source latency in cycles, 0..15
CNT_W, 12, width of counters and coordinates
DATA_W, 24, pixel data width

Ports:
clk_pix  in  1  pixel clock
rst  in  1  synchronous reset, active-high
en  in  1  run enable, sampled each clk_pix edge
req_valid  out  1  coordinate request valid (active area, lead stage)
req_x  out  CNT_W  requested pixel x (0 when !req_valid)
req_y  out  CNT_W  requested pixel y (0 when !req_valid)
pix_data_in  in  DATA_W  source data, valid exactly LEAD cycles after the matching req
vid_de  out  1  data enable to encoder
vid_hsync  out  1  hsync at configured polarity
vid_vsync  out  1  vsync at configured polarity
vid_data  out  DATA_W  pixel data aligned with vid_de (0 when !vid_de)
frame_start  out  1  one-cycle pulse with first DE of frame
line_start  out  1  one-cycle pulse with DE of x=0 on each active line
frame_cnt  out  16  frames started, wraps mod 2^16

Behaviour:
- One clock (clk_pix); reset is synchronous and active-high (rst).
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise. Counters h_cnt 0..H_TOTAL-1 and v_cnt 0..V_TOTAL-1 count exactly TOTAL. There is no off-by-one extra count.
- Line order: active, front porch, sync, back porch. Frame order: same, in whole lines.
- Counter update at each edge:
  - rst=1 or en=0: h_cnt, v_cnt <= 0.
  - else: h_cnt increments; at H_TOTAL-1 it wraps to 0 and v_cnt increments; v_cnt wraps at V_TOTAL-1.
- Stage 0 decode from the counter registers:
  - req_valid = !rst & en & h_cnt<H_ACTIVE & v_cnt<V_ACTIVE.
  - req_x/req_y = h_cnt/v_cnt when valid, else 0.
  - raw_h = h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC).
  - raw_v = v_cnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC), whole lines, edges at h_cnt=0.
  - sof = req_valid & x=0 & y=0; sol = req_valid & x=0.
- Delay pipeline: {valid, raw_h, raw_v, sof, sol} is carried through a LEAD-deep shift register, then one output register stage.
  - Outputs appear LEAD+1 cycles after the stage-0 decode.
  - vid_data is registered from pix_data_in in that same output stage when the delayed valid is 1, else 0.
  - With LEAD=0 the pipeline has no shift stages, only the output register.
- Stage-0 values are fed as inactive (0) while rst=1 or en=0. The pipeline drains naturally: outputs go inactive at most LEAD+1 cycles after en falls.
- Sync outputs: vid_hsync = raw_h_d ? H_SYNC_POL : !H_SYNC_POL; vid_vsync uses V_SYNC_POL the same way.
- frame_cnt increments in the cycle frame_start is high.
- Reset values of all registered outputs:
  - vid_de=0, vid_data=0, frame_start=0, line_start=0, frame_cnt=0.
  - vid_hsync=!H_SYNC_POL, vid_vsync=!V_SYNC_POL.
  - Pipeline cleared to inactive.
- en is re-checked every cycle. A drop mid-frame restarts at (0,0) when en returns. The restart produces a new frame_start and frame_cnt increment; a partial frame is not resumed.
- rst overrides en.
- Elaboration error if LEAD>15 or if H_TOTAL/V_TOTAL do not fit CNT_W.

Test Plan:
Small config for all scenarios: H 4/1/2/1 (total 8), V 3/1/1/1 (total 6), LEAD=2, positive polarity, cycle 0 = first edge after rst release with en=1.
1. Reset: hold rst=1 with en=1 -> req_valid=0, vid_de=0, vid_hsync=0, vid_vsync=0, frame_cnt=0, vid_data=0.
2. Timing: run 2 frames -> req_valid cycles 0-3 of each active line; vid_de cycles 3-6; vid_hsync high cycles 8-9 (h=5,6 delayed 3); vid_vsync high for 8 cycles starting cycle 35; frame_start at cycles 3 and 51; line_start at 3, 11, 19.
3. Alignment: source returns {y,x} with 2-cycle latency -> vid_data on line 0 DE cycles = 0x000000, 0x000001, 0x000002, 0x000003; 0 outside DE.
4. Polarity: H_SYNC_POL=0, V_SYNC_POL=0 -> hsync low only at cycles 8-9; vsync low only during v_cnt=4; both high after reset.
5. en drop: deassert en at h=2, line 0 for 5 cycles -> req_valid 0 next cycle, vid_de low within 3 cycles; on re-enable req (0,0), frame_start 3 cycles later, frame_cnt=2.
6. LEAD=0 variant, 3 full frames -> vid_de exactly 1 cycle after req_valid; frame_cnt=3 after 144 cycles; frame_cnt wraps 0xFFFF->0 with forced start.
